// File: rtl/chip8_stack_ctrl_pkg.sv
// Shared enums and constants for the CHIP-8 subroutine stack and its sequencer.
package chip8_stack_ctrl_pkg;

    typedef enum logic [1:0] {
        STACK_HOLD = 2'd0,
        STACK_PUSH = 2'd1,
        STACK_POP  = 2'd2
    } STACK_OP;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PUSH_A     = 3'd1,
        PUSH_B     = 3'd2,
        POP_RUN    = 3'd3,
        POP_SETTLE = 3'd4,
        RELEASE    = 3'd5,
        DONE       = 3'd6
    } STACK_CTRL_STATE;

    localparam int STK_DEPTH      = 16;
    localparam int STK_RET_STEP   = 2;
    localparam int STK_POP_CYCLES = 3;

endpackage

// File: rtl/chip8_stack_ctrl.sv
// Turns single-cycle CALL/RET requests into timed PUSH/POP/HOLD stack op sequences.
// Tracks depth and sticky overflow/underflow; requests seen while busy are dropped.
module chip8_stack_ctrl
    import chip8_stack_ctrl_pkg::*;
#(
    parameter int DEPTH      = STK_DEPTH,
    parameter int POP_CYCLES = STK_POP_CYCLES,
    parameter int RET_STEP   = STK_RET_STEP
) (
    input  logic                    cpu_clk,
    input  logic                    reset,
    input  logic                    req_call,
    input  logic                    req_ret,
    input  logic [11:0]             call_target,
    input  logic [15:0]             cur_pc,
    input  logic [15:0]             stk_outdata,
    output STACK_OP                 stk_op,
    output logic [15:0]             stk_writedata,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             pc_out,
    output logic [$clog2(DEPTH):0]  depth,
    output logic                    overflow_err,
    output logic                    underflow_err
);

    localparam int DW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(POP_CYCLES + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
    localparam logic [CW-1:0] POP_LOAD  = CW'(POP_CYCLES - 1);

    STACK_CTRL_STATE state, state_d;
    logic [15:0]     ret_addr, ret_addr_d;
    logic [15:0]     tgt, tgt_d;
    logic [CW-1:0]   pop_cnt, pop_cnt_d;
    logic [15:0]     pc_out_d;
    logic [DW-1:0]   depth_d;
    logic            overflow_err_d, underflow_err_d;

    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            state         <= IDLE;
            ret_addr      <= '0;
            tgt           <= '0;
            pop_cnt       <= '0;
            pc_out        <= '0;
            depth         <= '0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_d;
            ret_addr      <= ret_addr_d;
            tgt           <= tgt_d;
            pop_cnt       <= pop_cnt_d;
            pc_out        <= pc_out_d;
            depth         <= depth_d;
            overflow_err  <= overflow_err_d;
            underflow_err <= underflow_err_d;
        end
    end

    always_comb begin
        state_d         = state;
        ret_addr_d      = ret_addr;
        tgt_d           = tgt;
        pop_cnt_d       = pop_cnt;
        pc_out_d        = pc_out;
        depth_d         = depth;
        overflow_err_d  = overflow_err;
        underflow_err_d = underflow_err;
        stk_op          = STACK_HOLD;
        stk_writedata   = '0;
        busy            = (state != IDLE);
        done            = 1'b0;

        case (state)
            IDLE: begin
                // CALL has priority; a simultaneous RET is simply lost.
                if (req_call) begin
                    ret_addr_d = cur_pc + 16'(RET_STEP);
                    tgt_d      = {4'h0, call_target};
                    if (depth == DEPTH_MAX) begin
                        overflow_err_d = 1'b1;
                        pc_out_d       = {4'h0, call_target};
                        state_d        = DONE;
                    end else begin
                        state_d = PUSH_A;
                    end
                end else if (req_ret) begin
                    if (depth == '0) begin
                        underflow_err_d = 1'b1;
                        pc_out_d        = cur_pc;
                        state_d         = DONE;
                    end else begin
                        pop_cnt_d = POP_LOAD;
                        state_d   = POP_RUN;
                    end
                end
            end
            PUSH_A: begin
                stk_op        = STACK_PUSH;
                stk_writedata = ret_addr;
                state_d       = PUSH_B;
            end
            PUSH_B: begin
                stk_op        = STACK_PUSH;
                stk_writedata = ret_addr;
                if (depth != DEPTH_MAX) depth_d = depth + 1'b1;
                pc_out_d      = tgt;
                state_d       = RELEASE;
            end
            POP_RUN: begin
                stk_op = STACK_POP;
                if (pop_cnt == '0) state_d = POP_SETTLE;
                else               pop_cnt_d = pop_cnt - 1'b1;
            end
            POP_SETTLE: begin
                pc_out_d = stk_outdata;
                if (depth != '0) depth_d = depth - 1'b1;
                state_d  = DONE;
            end
            RELEASE: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_chip8_stack_ctrl.sv
// Directed bench for chip8_stack_ctrl: transaction-level model plus literal checks.
module tb_chip8_stack_ctrl;
    import chip8_stack_ctrl_pkg::*;

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_call = 1'b0;
    logic        req_ret = 1'b0;
    logic [11:0] call_target = '0;
    logic [15:0] cur_pc = '0;
    logic [15:0] stk_outdata = '0;
    STACK_OP     stk_op;
    logic [15:0] stk_writedata;
    logic        busy, done;
    logic [15:0] pc_out;
    logic [4:0]  depth;
    logic        overflow_err, underflow_err;

    int checks = 0;
    int errors = 0;

    chip8_stack_ctrl dut (
        .cpu_clk(cpu_clk), .reset(reset), .req_call(req_call), .req_ret(req_ret),
        .call_target(call_target), .cur_pc(cur_pc), .stk_outdata(stk_outdata),
        .stk_op(stk_op), .stk_writedata(stk_writedata), .busy(busy), .done(done),
        .pc_out(pc_out), .depth(depth), .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Stack memory: a held PUSH writes one entry, a held POP reads one entry.
    logic [15:0] p_stack[$];
    STACK_OP     prev_op = STACK_HOLD;
    always @(posedge cpu_clk) begin
        if (reset) begin
            p_stack.delete();
            stk_outdata <= '0;
        end else begin
            if (stk_op == STACK_PUSH && prev_op != STACK_PUSH) p_stack.push_back(stk_writedata);
            if (stk_op == STACK_POP && prev_op != STACK_POP && p_stack.size() > 0)
                stk_outdata <= p_stack.pop_back();
        end
        prev_op <= stk_op;
    end

    // Model: per-cycle expected outputs, scheduled when a request is accepted.
    typedef struct {
        STACK_OP     op;
        logic [15:0] wd;
        logic        busy;
        logic        done;
        logic [15:0] pc;
        int          dep;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sched[$];
    exp_t        cur;
    logic [15:0] m_stack[$];
    logic        m_ovf = 1'b0, m_unf = 1'b0, model_on = 1'b0;

    function automatic exp_t mk(STACK_OP op, logic [15:0] wd, logic b, logic d,
                                logic [15:0] pc, int dep, logic ovf, logic unf);
        exp_t e;
        e.op = op; e.wd = wd; e.busy = b; e.done = d; e.pc = pc; e.dep = dep;
        e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    always @(posedge cpu_clk) begin
        logic [15:0] ra, tg, pv;
        if (reset) begin
            sched.delete();
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            cur = mk(STACK_HOLD, 16'h0, 1'b0, 1'b0, 16'h0, 0, 1'b0, 1'b0);
            model_on = 1'b1;
        end else if (model_on) begin
            if (sched.size() == 0 && !cur.busy) begin
                if (req_call) begin
                    ra = cur_pc + 16'd2;
                    tg = {4'h0, call_target};
                    if (m_stack.size() == 16) begin
                        m_ovf = 1'b1;
                        sched.push_back(mk(STACK_HOLD, 0, 1, 1, tg, 16, m_ovf, m_unf));
                    end else begin
                        m_stack.push_back(ra);
                        sched.push_back(mk(STACK_PUSH, ra, 1, 0, 0, 0, m_ovf, m_unf));
                        sched.push_back(mk(STACK_PUSH, ra, 1, 0, 0, 0, m_ovf, m_unf));
                        sched.push_back(mk(STACK_HOLD, 0, 1, 0, 0, 0, m_ovf, m_unf));
                        sched.push_back(mk(STACK_HOLD, 0, 1, 1, tg, m_stack.size(), m_ovf, m_unf));
                    end
                end else if (req_ret) begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1'b1;
                        sched.push_back(mk(STACK_HOLD, 0, 1, 1, cur_pc, 0, m_ovf, m_unf));
                    end else begin
                        pv = m_stack.pop_back();
                        for (int i = 0; i < 3; i++)
                            sched.push_back(mk(STACK_POP, 0, 1, 0, 0, 0, m_ovf, m_unf));
                        sched.push_back(mk(STACK_HOLD, 0, 1, 0, 0, 0, m_ovf, m_unf));
                        sched.push_back(mk(STACK_HOLD, 0, 1, 1, pv, m_stack.size(), m_ovf, m_unf));
                    end
                end
            end
            if (sched.size() > 0) cur = sched.pop_front();
            else cur = mk(STACK_HOLD, 0, 0, 0, 0, m_stack.size(), m_ovf, m_unf);
        end
    end

    always @(negedge cpu_clk) begin
        if (model_on) begin
            chk("stk_op", 32'(stk_op), 32'(cur.op));
            chk("busy", 32'(busy), 32'(cur.busy));
            chk("done", 32'(done), 32'(cur.done));
            chk("overflow_err", 32'(overflow_err), 32'(cur.ovf));
            chk("underflow_err", 32'(underflow_err), 32'(cur.unf));
            if (cur.op == STACK_PUSH) chk("stk_writedata", 32'(stk_writedata), 32'(cur.wd));
            if (cur.done) chk("pc_out", 32'(pc_out), 32'(cur.pc));
            if (cur.done || !cur.busy) chk("depth", 32'(depth), cur.dep[31:0]);
        end
    end

    task automatic req(input logic c, input logic r, input logic [11:0] tgt, input logic [15:0] pc);
        @(posedge cpu_clk); #1;
        req_call = c; req_ret = r; call_target = tgt; cur_pc = pc;
        @(posedge cpu_clk); #1;
        req_call = 1'b0; req_ret = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int exp_lat, output logic [15:0] pc_o,
                             output logic [4:0] dep_o);
        int lat = 0;
        pc_o = '0;
        dep_o = '0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge cpu_clk);
            if (done) begin
                lat = n;
                pc_o = pc_out;
                dep_o = depth;
                break;
            end
        end
        chk(nm, lat, exp_lat);
    endtask

    initial begin
        logic [15:0] pc;
        logic [4:0]  d;

        repeat (3) @(posedge cpu_clk);
        #1 reset = 1'b0;
        @(negedge cpu_clk);
        chk("reset_depth", 32'(depth), 0);
        chk("reset_op", 32'(stk_op), 32'(STACK_HOLD));
        chk("reset_pc", 32'(pc_out), 0);

        // Basic call and return.
        req(1, 0, 12'h345, 16'h0200);
        wait_done("call_lat", 4, pc, d);
        chk("call_pc", 32'(pc), 32'h0345);
        chk("call_depth", 32'(d), 1);
        chk("call_pushed", 32'(p_stack[0]), 32'h0202);
        req(0, 1, 12'h000, 16'h0345);
        wait_done("ret_lat", 5, pc, d);
        chk("ret_pc", 32'(pc), 32'h0202);
        chk("ret_depth", 32'(d), 0);

        // Fill to 16, overflow, then unwind in LIFO order.
        for (int i = 0; i < 16; i++) begin
            req(1, 0, 12'(i), 16'h0200 + 16'(2 * i));
            wait_done("fill_lat", 4, pc, d);
        end
        chk("fill_depth", 32'(d), 16);
        req(1, 0, 12'h777, 16'h0300);
        wait_done("ovf_lat", 1, pc, d);
        chk("ovf_flag", 32'(overflow_err), 1);
        chk("ovf_pc", 32'(pc), 32'h0777);
        chk("ovf_depth", 32'(d), 16);
        for (int k = 0; k < 16; k++) begin
            req(0, 1, 12'h000, 16'h0400);
            wait_done("unwind_lat", 5, pc, d);
            chk("unwind_pc", 32'(pc), 32'h0220 - 32'(2 * k));
        end
        chk("unwind_depth", 32'(d), 0);

        // Underflow.
        req(0, 1, 12'h000, 16'h0ABC);
        wait_done("unf_lat", 1, pc, d);
        chk("unf_flag", 32'(underflow_err), 1);
        chk("unf_pc", 32'(pc), 32'h0ABC);

        // Simultaneous CALL+RET, CALL while busy, PC wrap.
        req(1, 1, 12'h111, 16'h0300);
        wait_done("both_lat", 4, pc, d);
        chk("both_depth", 32'(d), 1);
        req(1, 0, 12'h222, 16'h0500);
        req_call = 1'b1; cur_pc = 16'h0600; call_target = 12'h999;
        @(posedge cpu_clk); #1 req_call = 1'b0;
        wait_done("busy_lat", 3, pc, d);
        chk("busy_pc", 32'(pc), 32'h0222);
        chk("busy_depth", 32'(d), 2);
        req(1, 0, 12'h0AA, 16'hFFFF);
        wait_done("wrap_lat", 4, pc, d);
        req(0, 1, 12'h000, 16'h00AA);
        wait_done("wrap_lat_ret", 5, pc, d);
        chk("wrap_pc", 32'(pc), 32'h0001);
        chk("wrap_depth", 32'(d), 2);

        // Reset during PUSH_B.
        req(1, 0, 12'h123, 16'h0700);
        @(posedge cpu_clk); #1 reset = 1'b1;
        @(posedge cpu_clk); #1 reset = 1'b0;
        @(negedge cpu_clk);
        chk("rstpush_op", 32'(stk_op), 32'(STACK_HOLD));
        chk("rstpush_depth", 32'(depth), 0);
        chk("rstpush_busy", 32'(busy), 0);
        chk("rstpush_done", 32'(done), 0);

        // Reset during POP_RUN.
        req(1, 0, 12'h456, 16'h0800);
        wait_done("pre_pop_lat", 4, pc, d);
        req(0, 1, 12'h000, 16'h0456);
        reset = 1'b1;
        @(posedge cpu_clk); #1 reset = 1'b0;
        @(negedge cpu_clk);
        chk("rstpop_op", 32'(stk_op), 32'(STACK_HOLD));
        chk("rstpop_depth", 32'(depth), 0);
        chk("rstpop_busy", 32'(busy), 0);
        chk("rstpop_done", 32'(done), 0);
        repeat (3) @(negedge cpu_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
